button_event: RTL



---
 rtl/button_event_pkg.sv | 16 +
 rtl/button_event_ch.sv | 111 +++++++++++
 rtl/button_event.sv | 51 +++++
 3 files changed

// File: rtl/button_event_pkg.sv
// Shared types and helpers for the per-button event decoder.
package button_event_pkg;

   typedef enum logic [1:0] {
      LOCKOUT,
      IDLE,
      PRESSED,
      HELD
   } btn_state_t;

   // Counter width covering both thresholds (counter never exceeds max-1).
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      return $clog2((a > b) ? a : b);
   endfunction

endpackage

// File: rtl/button_event_ch.sv
// One button channel: lockout/idle/pressed/held FSM with hold counter and registered pulses.
module button_event_ch
   import button_event_pkg::*;
#(
   parameter int unsigned LONG_CYCLES   = 25_000_000,
   parameter int unsigned REPEAT_CYCLES = 5_000_000,
   parameter bit          REPEAT_EN     = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_button,
   output logic o_press,
   output logic o_release,
   output logic o_click,
   output logic o_long_press,
   output logic o_repeat,
   output logic o_held,
   output logic o_event_d
);

   localparam int unsigned     CntW    = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
   localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);
   localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYCLES - 1);

   btn_state_t      r_state, w_state_d;
   logic [CntW-1:0] r_cnt, w_cnt_d;
   logic            w_press_d, w_release_d, w_click_d, w_long_d, w_repeat_d, w_held_d;

   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt;
      w_press_d   = 1'b0;
      w_release_d = 1'b0;
      w_click_d   = 1'b0;
      w_long_d    = 1'b0;
      w_repeat_d  = 1'b0;
      unique case (r_state)
         LOCKOUT: begin
            if (!i_button) w_state_d = IDLE;
         end
         IDLE: begin
            if (i_button) begin
               w_press_d = 1'b1;
               w_cnt_d   = '0;
               w_state_d = PRESSED;
            end
         end
         PRESSED: begin
            // Release wins over the long threshold in the same cycle.
            if (!i_button) begin
               w_release_d = 1'b1;
               w_click_d   = 1'b1;
               w_cnt_d     = '0;
               w_state_d   = IDLE;
            end else if (r_cnt == LongLast) begin
               w_long_d  = 1'b1;
               w_cnt_d   = '0;
               w_state_d = HELD;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         HELD: begin
            if (!i_button) begin
               w_release_d = 1'b1;
               w_cnt_d     = '0;
               w_state_d   = IDLE;
            end else if (REPEAT_EN) begin
               if (r_cnt == RepLast) begin
                  w_repeat_d = 1'b1;
                  w_cnt_d    = '0;
               end else begin
                  w_cnt_d = r_cnt + 1'b1;
               end
            end else begin
               w_cnt_d = '0;
            end
         end
         default: begin
            w_state_d = LOCKOUT;
            w_cnt_d   = '0;
         end
      endcase
   end

   assign w_held_d  = (w_state_d == PRESSED) || (w_state_d == HELD);
   assign o_event_d = w_press_d | w_release_d | w_click_d | w_long_d | w_repeat_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= LOCKOUT;
         r_cnt        <= '0;
         o_press      <= 1'b0;
         o_release    <= 1'b0;
         o_click      <= 1'b0;
         o_long_press <= 1'b0;
         o_repeat     <= 1'b0;
         o_held       <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_cnt        <= w_cnt_d;
         o_press      <= w_press_d;
         o_release    <= w_release_d;
         o_click      <= w_click_d;
         o_long_press <= w_long_d;
         o_repeat     <= w_repeat_d;
         o_held       <= w_held_d;
      end
   end

endmodule

// File: rtl/button_event.sv
// Button event decoder: independent per-button channels plus a shared any-event pulse.
module button_event
   import button_event_pkg::*;
#(
   parameter int unsigned NUM_BUTTONS   = 4,
   parameter int unsigned LONG_CYCLES   = 25_000_000,
   parameter int unsigned REPEAT_CYCLES = 5_000_000,
   parameter bit          REPEAT_EN     = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_BUTTONS-1:0] i_button,
   output logic [NUM_BUTTONS-1:0] o_press,
   output logic [NUM_BUTTONS-1:0] o_release,
   output logic [NUM_BUTTONS-1:0] o_click,
   output logic [NUM_BUTTONS-1:0] o_long_press,
   output logic [NUM_BUTTONS-1:0] o_repeat,
   output logic [NUM_BUTTONS-1:0] o_held,
   output logic                   o_any_event
);

   logic [NUM_BUTTONS-1:0] w_event_d;

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
      button_event_ch #(
         .LONG_CYCLES  (LONG_CYCLES),
         .REPEAT_CYCLES(REPEAT_CYCLES),
         .REPEAT_EN    (REPEAT_EN)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_button    (i_button[g]),
         .o_press     (o_press[g]),
         .o_release   (o_release[g]),
         .o_click     (o_click[g]),
         .o_long_press(o_long_press[g]),
         .o_repeat    (o_repeat[g]),
         .o_held      (o_held[g]),
         .o_event_d   (w_event_d[g])
      );
   end

   // Registered from next-state pulses so it lines up with the channel outputs.
   logic r_any_event;
   always_ff @(posedge clk) begin
      if (!rst_n) r_any_event <= 1'b0;
      else        r_any_event <= |w_event_d;
   end
   assign o_any_event = r_any_event;

endmodule
